// File: rtl/count_event_monitor.sv
// count_event_monitor
//   Watches the count output of an up/down counter, sampling it every clock
//   and classifying each transition as a wrap-around, a direction reversal
//   or an illegal jump. Each classified event is queued in a small
//   first-word-fall-through FIFO behind a valid/ready interface. The module
//   also keeps a saturating wrap tally and the tracked direction.
//
//   Ports
//     clk        rising-edge clock
//     reset      asynchronous active-low reset (0 = in reset)
//     count      counter value being monitored
//     clr        synchronous clear: flush FIFO, zero overflow/wrap_total,
//                direction -> unknown
//     evt_ready  consumer accepts the head event
//     evt_valid  FIFO non-empty
//     evt_code   head event: 1 WRAP_UP, 2 WRAP_DN, 3 REV_TO_UP,
//                4 REV_TO_DN, 5 JUMP
//     evt_value  count value that caused the head event
//     wrap_total wraps seen since reset/clr, saturating at all-ones
//     dir_state  0 unknown, 1 up, 2 down
//     overflow   sticky: an event was dropped on a full FIFO
module count_event_monitor #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SAT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count,
    input  logic             clr,
    input  logic             evt_ready,
    output logic             evt_valid,
    output logic [2:0]       evt_code,
    output logic [WIDTH-1:0] evt_value,
    output logic [SAT_W-1:0] wrap_total,
    output logic [1:0]       dir_state,
    output logic             overflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WIDTH-1:0] MAXV = '1;
    localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_INIT, S_UNK, S_UP, S_DOWN} state_t;
    typedef enum logic [2:0] {
        EV_NONE    = 3'd0,
        EV_WRAP_UP = 3'd1,
        EV_WRAP_DN = 3'd2,
        EV_REV_UP  = 3'd3,
        EV_REV_DN  = 3'd4,
        EV_JUMP    = 3'd5
    } evt_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] delta;
    logic             wrap_up;
    logic             wrap_dn;
    logic             wrap_hit;
    evt_t             ev;
    logic [1:0]       dir_n;

    logic [2:0]       mem_code [DEPTH];
    logic [WIDTH-1:0] mem_val  [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_n;
    logic [AW:0]      rd_n;
    logic [AW:0]      occ;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;
    logic [2:0]       head_code_n;
    logic [WIDTH-1:0] head_val_n;

    // Transition classification. A wrap is always a +1/-1 step, so it only
    // becomes the pushed event when that step is not also a reversal.
    always_comb begin
        delta    = count - prev;
        wrap_up  = (prev == MAXV) && (count == '0);
        wrap_dn  = (prev == '0) && (count == MAXV);
        state_n  = state;
        ev       = EV_NONE;
        wrap_hit = 1'b0;
        if (state == S_INIT) begin
            state_n = S_UNK;
        end else begin
            wrap_hit = wrap_up | wrap_dn;
            if (delta == WIDTH'(1)) begin
                state_n = S_UP;
                if (state == S_DOWN)
                    ev = EV_REV_UP;
                else if (wrap_up)
                    ev = EV_WRAP_UP;
            end else if (delta == MAXV) begin
                state_n = S_DOWN;
                if (state == S_UP)
                    ev = EV_REV_DN;
                else if (wrap_dn)
                    ev = EV_WRAP_DN;
            end else if (delta != '0) begin
                ev      = EV_JUMP;
                state_n = S_UNK;
            end
        end
    end

    always_comb begin
        case (state_n)
            S_UP:    dir_n = 2'd1;
            S_DOWN:  dir_n = 2'd2;
            default: dir_n = 2'd0;
        endcase
    end

    // FIFO control. A pop on a full FIFO frees the slot the push lands in.
    always_comb begin
        occ  = wr_ptr - rd_ptr;
        full = (occ == DEPTH_P);
        pop  = evt_valid & evt_ready;
        push = (ev != EV_NONE) & (~full | pop);
        drop = (ev != EV_NONE) & full & ~pop;
        rd_n = rd_ptr + (AW+1)'(pop);
        wr_n = wr_ptr + (AW+1)'(push);
        // Next head is the incoming event when it lands in the head slot
        // (FIFO empty after any pop), otherwise whatever the read pointer
        // points at.
        if (push && (rd_n[AW-1:0] == wr_ptr[AW-1:0])) begin
            head_code_n = ev;
            head_val_n  = count;
        end else begin
            head_code_n = mem_code[rd_n[AW-1:0]];
            head_val_n  = mem_val[rd_n[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_code[wr_ptr[AW-1:0]] <= ev;
            mem_val[wr_ptr[AW-1:0]]  <= count;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_INIT;
            prev       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            evt_valid  <= 1'b0;
            evt_code   <= '0;
            evt_value  <= '0;
            wrap_total <= '0;
            dir_state  <= 2'd0;
            overflow   <= 1'b0;
        end else begin
            prev <= count;
            if (clr) begin
                state      <= S_UNK;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                evt_valid  <= 1'b0;
                wrap_total <= '0;
                dir_state  <= 2'd0;
                overflow   <= 1'b0;
            end else begin
                state     <= state_n;
                dir_state <= dir_n;
                wr_ptr    <= wr_n;
                rd_ptr    <= rd_n;
                evt_valid <= (wr_n != rd_n);
                // Head registers keep their last value while empty.
                if (wr_n != rd_n) begin
                    evt_code  <= head_code_n;
                    evt_value <= head_val_n;
                end
                if (wrap_hit && (wrap_total != '1))
                    wrap_total <= wrap_total + SAT_W'(1);
                if (drop)
                    overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_count_event_monitor.sv
module tb_count_event_monitor;

    localparam int W      = 4;
    localparam int D      = 4;
    localparam int SW     = 3;
    localparam int MAXC   = (1 << W) - 1;
    localparam int SATMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  count;
    logic          clr;
    logic          evt_ready;
    logic          evt_valid;
    logic [2:0]    evt_code;
    logic [W-1:0]  evt_value;
    logic [SW-1:0] wrap_total;
    logic [1:0]    dir_state;
    logic          overflow;

    int tests = 0;
    int fails = 0;

    // Expected FIFO contents, {code, value}; the head is sb[0].
    bit [6:0] sb[$];
    int  m_prev;
    int  m_dir;
    int  m_wt;
    bit  m_ovf;
    bit  m_init;
    int  cur;

    count_event_monitor #(.WIDTH(W), .DEPTH(D), .SAT_W(SW)) dut (
        .clk        (clk),
        .reset      (reset),
        .count      (count),
        .clr        (clr),
        .evt_ready  (evt_ready),
        .evt_valid  (evt_valid),
        .evt_code   (evt_code),
        .evt_value  (evt_value),
        .wrap_total (wrap_total),
        .dir_state  (dir_state),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the post-edge DUT state against the model, then
    // retires the head if the consumer takes it at the coming edge.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            check("evt_valid", evt_valid, (sb.size() != 0) ? 1 : 0);
            if (sb.size() != 0) begin
                check("evt_code", evt_code, sb[0][6:4]);
                check("evt_value", evt_value, sb[0][3:0]);
            end
            check("wrap_total", wrap_total, m_wt);
            check("dir_state", dir_state, m_dir);
            check("overflow", overflow, m_ovf);
            if (sb.size() != 0 && evt_ready && !clr)
                void'(sb.pop_front());
        end
    end

    // Reference behaviour for one sampling edge, pops already retired.
    task automatic model_edge(input int c, input bit cl);
        int d;
        int wrap;
        int code;
        if (m_init) begin
            m_init = 0;
            m_prev = c;
            m_dir  = 0;
            if (cl) begin
                sb.delete();
                m_ovf = 0;
                m_wt  = 0;
            end
            return;
        end
        d    = (c - m_prev) & MAXC;
        wrap = 0;
        if (m_prev == MAXC && c == 0) wrap = 1;
        if (m_prev == 0 && c == MAXC) wrap = 2;
        code = 0;
        if (d == 1) begin
            code  = (m_dir == 2) ? 3 : (wrap == 1 ? 1 : 0);
            m_dir = 1;
        end else if (d == MAXC) begin
            code  = (m_dir == 1) ? 4 : (wrap == 2 ? 2 : 0);
            m_dir = 2;
        end else if (d != 0) begin
            code  = 5;
            m_dir = 0;
        end
        if (wrap != 0 && m_wt < SATMAX) m_wt++;
        m_prev = c;
        if (cl) begin
            sb.delete();
            m_ovf = 0;
            m_wt  = 0;
            m_dir = 0;
            return;
        end
        if (code != 0) begin
            if (sb.size() < D) sb.push_back({3'(code), 4'(c)});
            else m_ovf = 1;
        end
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic step(input int c, input bit cl, input bit rdy);
        count     = W'(c);
        clr       = cl;
        evt_ready = rdy;
        cur       = c;
        @(negedge clk);
        #1;
        model_edge(c, cl);
        @(posedge clk);
        #1;
    endtask

    task automatic up_steps(input int n, input bit rdy);
        for (int k = 0; k < n; k++) step((cur + 1) & MAXC, 1'b0, rdy);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        check("rst_evt_valid", evt_valid, 0);
        check("rst_evt_code", evt_code, 0);
        check("rst_evt_value", evt_value, 0);
        check("rst_wrap_total", wrap_total, 0);
        check("rst_dir_state", dir_state, 0);
        check("rst_overflow", overflow, 0);
        sb.delete();
        m_wt   = 0;
        m_dir  = 0;
        m_ovf  = 0;
        m_init = 1;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        clr       = 1'b0;
        evt_ready = 1'b0;
        count     = '0;
        cur       = 0;
        m_init    = 1;
        m_wt      = 0;
        m_dir     = 0;
        m_ovf     = 0;
        m_prev    = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset with two events queued, then restart tracking.
        step(7, 0, 0);
        step(8, 0, 0);
        check("t1_dir_up", dir_state, 1);
        step(3, 0, 0);
        step(9, 0, 0);
        check("t1_two_queued", evt_valid, 1);
        pulse_reset();
        step(7, 0, 0);
        step(8, 0, 0);
        check("t1_no_event", evt_valid, 0);
        check("t1_dir_after", dir_state, 1);

        // Single up wrap.
        step(12, 1, 0);
        step(13, 0, 0); step(14, 0, 0); step(15, 0, 0); step(0, 0, 0); step(1, 0, 0);
        check("t2_wrap_total", wrap_total, 1);
        check("t2_code", evt_code, 1);

        // Reversals; then reversal taking precedence over a down wrap.
        step(2, 1, 1);
        step(3, 0, 0); step(4, 0, 0); step(5, 0, 0); step(4, 0, 0); step(5, 0, 0);
        check("t3_dir", dir_state, 1);
        step(14, 1, 1);
        step(15, 0, 0); step(0, 0, 0); step(15, 0, 0);
        check("t3_wrap_total", wrap_total, 2);
        step(15, 0, 1); step(15, 0, 1); step(15, 0, 1);

        // Jump.
        step(2, 1, 1);
        step(3, 0, 0); step(9, 0, 0);
        check("t4_jump_dir", dir_state, 0);
        check("t4_jump_code", evt_code, 5);
        step(10, 0, 0);
        check("t4_dir", dir_state, 1);

        // Five wraps into a four-deep FIFO, drain, clear.
        step(0, 1, 1);
        up_steps(80, 0);
        check("t5_overflow", overflow, 1);
        for (int k = 0; k < 5; k++) step(0, 0, 1);
        check("t5_drained", evt_valid, 0);
        step(0, 1, 0);
        check("t5_clr_ovf", overflow, 0);
        check("t5_clr_wt", wrap_total, 0);

        // Full FIFO, pop and wrap push on the same edge.
        up_steps(64, 0);
        up_steps(15, 0);
        step(0, 0, 1);
        check("t6_no_overflow", overflow, 0);
        step(0, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 1);

        // Saturation of the wrap tally.
        step(0, 1, 1);
        up_steps(16 * 9, 1);
        check("sat_wrap_total", wrap_total, SATMAX);

        // Randomized walk.
        for (int k = 0; k < 800; k++) begin
            int r;
            int nc;
            bit cl;
            bit rdy;
            r  = $urandom_range(0, 99);
            if (r < 40)      nc = (cur + 1) & MAXC;
            else if (r < 80) nc = (cur - 1) & MAXC;
            else if (r < 88) nc = cur;
            else             nc = $urandom_range(0, MAXC);
            cl  = ($urandom_range(0, 99) < 2);
            rdy = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 199) == 0) pulse_reset();
            else step(nc, cl, rdy);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
